stopwatch_ctrl: RTL

- Upstream control stage for the 00–99 multiplexed counter display.
- Debounces two raw push-buttons: start/stop and clear.
- Runs a run/pause/done state machine that drives the counter's enable input and a clear pulse for the counter's reset.
- Optionally halts counting when the counter reports 99 via its carry output.

---
 rtl/stopwatch_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Control stage for the 00-99 counter display: debounces start/clear buttons and
// runs the IDLE/RUN/PAUSE/DONE machine that drives the counter enable and clear.
module stopwatch_ctrl #(
   parameter int unsigned DB_BITS     = 16,
   parameter bit          STOP_AT_MAX = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       carry_in,
   output logic       enable_out,
   output logic       clear_out,
   output logic [1:0] state_out,
   output logic       press_start
);

   localparam int unsigned NBTN    = 2;
   localparam int unsigned B_START = 0;
   localparam int unsigned B_CLEAR = 1;
   localparam int unsigned NSYNC   = NBTN + 1;
   localparam int unsigned B_CARRY = NBTN;
   localparam logic [DB_BITS-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   logic [NSYNC-1:0]              meta_q;
   logic [NSYNC-1:0]              sync_q;
   logic [NBTN-1:0]               lvl_q;
   logic [NBTN-1:0][DB_BITS-1:0]  cnt_q;
   logic [NBTN-1:0]               press_q;
   state_e                        state_q;
   state_e                        state_d;
   logic                          clear_d;
   logic                          enable_q;
   logic                          clear_q;

   // Two-flop synchronisers, then per-button debounce with a rising-edge strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q  <= '0;
         sync_q  <= '0;
         lvl_q   <= '0;
         cnt_q   <= '0;
         press_q <= '0;
      end else begin
         meta_q <= {carry_in, btn_clear, btn_start};
         sync_q <= meta_q;
         for (int i = 0; i < int'(NBTN); i++) begin
            press_q[i] <= 1'b0;
            if (sync_q[i] == lvl_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               lvl_q[i]   <= sync_q[i];
               cnt_q[i]   <= '0;
               press_q[i] <= sync_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + DB_BITS'(1);
            end
         end
      end
   end

   // Next state with priority clear > carry > start
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (press_q[B_CLEAR]) begin
         state_d = ST_IDLE;
         clear_d = 1'b1;
      end else if (STOP_AT_MAX && (state_q == ST_RUN) && sync_q[B_CARRY]) begin
         state_d = ST_DONE;
      end else if (press_q[B_START]) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end
   end

   // Enable is registered from the next state so it moves together with state_out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         clear_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         enable_q <= (state_d == ST_RUN);
         clear_q  <= clear_d;
      end
   end

   assign state_out   = state_q;
   assign enable_out  = enable_q;
   assign clear_out   = clear_q;
   assign press_start = press_q[B_START];

endmodule
